seq_mul_add: RTL and testbench

//   Iterative unsigned multiply-add: p = x*y + c, with N-bit operands and a 2N-bit result.

---
 rtl/seq_mul_add.sv | 84 ++++++++
 tb/tb_seq_mul_add.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mul_add.sv
// Iterative unsigned multiply-add p = x*y + c.
// One bit of y is retired per clock through a single N-bit adder; the running
// sum's high half lives in acc and the retired low bits shift into lo, so the
// final product is simply {acc, lo}. The addend c is preloaded into acc, where
// the N right shifts bring it down to weight 2^0.
module seq_mul_add #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           start,
  output logic           ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic [N-1:0]   c,
  output logic [2*N-1:0] p,
  output logic           done,
  input  logic           ack
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, nxt;
  logic [N-1:0]  acc, lo, ymul, xreg;
  logic [CW-1:0] cnt;
  logic [N:0]    sum;
  logic          last;

  // One N-by-1 partial-product row added to the running high half.
  assign sum  = {1'b0, acc} + (ymul[0] ? {1'b0, xreg} : {(N+1){1'b0}});
  assign last = (cnt == CW'(N-1));
  assign p    = {acc, lo};

  // State register; ready/done are flopped from the next state so they are
  // true register outputs, not decodes.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      ready <= (nxt == IDLE);
      done  <= (nxt == DONE);
    end
  end

  // Next-state: start only matters in IDLE, ack only in DONE, so a
  // simultaneous start+ack in DONE just returns to IDLE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    if (ack)   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Datapath: operands captured at the accepting start, then N shift-add steps.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      acc  <= '0;
      lo   <= '0;
      ymul <= '0;
      xreg <= '0;
      cnt  <= '0;
    end else if (state == IDLE && start) begin
      acc  <= c;
      lo   <= '0;
      ymul <= y;
      xreg <= x;
      cnt  <= '0;
    end else if (state == RUN) begin
      lo   <= {sum[0], lo[N-1:1]};
      acc  <= sum[N:1];
      ymul <= ymul >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_mul_add.sv
// Bench for seq_mul_add: an N=4 and an N=8 instance sharing clock and reset.
// Expected results are queued when an operation is started and popped when
// the instance raises done.
module tb_seq_mul_add;

  logic        clock = 1'b0;
  logic        reset_ = 1'b0;

  logic        start4 = 1'b0, ack4 = 1'b0, ready4, done4;
  logic [3:0]  x4 = '0, y4 = '0, c4 = '0;
  logic [7:0]  p4;

  logic        start8 = 1'b0, ack8 = 1'b0, ready8, done8;
  logic [7:0]  x8 = '0, y8 = '0, c8 = '0;
  logic [15:0] p8;

  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  seq_mul_add #(.N(4)) dut4 (
    .clock(clock), .reset_(reset_), .start(start4), .ready(ready4),
    .x(x4), .y(y4), .c(c4), .p(p4), .done(done4), .ack(ack4)
  );

  seq_mul_add #(.N(8)) dut8 (
    .clock(clock), .reset_(reset_), .start(start8), .ready(ready8),
    .x(x8), .y(y8), .c(c8), .p(p8), .done(done8), .ack(ack8)
  );

  // ---- stimulus helpers (no checking inside) ----
  task automatic start_op4(input int x, input int y, input int c);
    int e;
    @(negedge clock);
    x4 = 4'(x); y4 = 4'(y); c4 = 4'(c); start4 = 1'b1;
    e = x * y + c;
    q4.push_back(8'(e));
    @(negedge clock);
    start4 = 1'b0;
  endtask

  task automatic start_op8(input int x, input int y, input int c);
    int e;
    @(negedge clock);
    x8 = 8'(x); y8 = 8'(y); c8 = 8'(c); start8 = 1'b1;
    e = x * y + c;
    q8.push_back(16'(e));
    @(negedge clock);
    start8 = 1'b0;
  endtask

  task automatic wait_done4(output bit to);
    int n;
    n = 0;
    while (done4 !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    to = (done4 !== 1'b1);
  endtask

  task automatic wait_done8(output bit to);
    int n;
    n = 0;
    while (done8 !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    to = (done8 !== 1'b1);
  endtask

  task automatic do_ack4();
    ack4 = 1'b1;
    @(negedge clock);
    ack4 = 1'b0;
  endtask

  task automatic do_ack8();
    ack8 = 1'b1;
    @(negedge clock);
    ack8 = 1'b0;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset_ = 1'b0;
    repeat (2) @(negedge clock);
    n_chk++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready4 got %b exp 1", ready4); end
    n_chk++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got %b exp 0", done4); end
    n_chk++; if (p4 !== 8'd0) begin n_fail++; $display("FAIL reset_p4 got %0d exp 0", p4); end
    n_chk++; if (ready8 !== 1'b1 || done8 !== 1'b0 || p8 !== 16'd0) begin
      n_fail++; $display("FAIL reset_dut8 got ready=%b done=%b p=%0d exp 1 0 0", ready8, done8, p8);
    end
    reset_ = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_latency_hold();
    logic [7:0] e;
    start_op4(15, 15, 15);
    // now just after the start edge; done must rise only after edge 5
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (done4 !== 1'b0 || ready4 !== 1'b0) begin
        n_fail++; $display("FAIL latency_run step %0d got done=%b ready=%b exp 0 0", i, done4, ready4);
      end
      @(negedge clock);
    end
    e = q4.pop_front();
    n_chk++; if (done4 !== 1'b1) begin n_fail++; $display("FAIL latency_done got %b exp 1", done4); end
    n_chk++; if (p4 !== e) begin n_fail++; $display("FAIL max4_p got %0d exp %0d", p4, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_chk++; if (done4 !== 1'b1 || p4 !== e || ready4 !== 1'b0) begin
        n_fail++; $display("FAIL hold_stable got done=%b ready=%b p=%0d exp 1 0 %0d", done4, ready4, p4, e);
      end
    end
    do_ack4();
    n_chk++; if (ready4 !== 1'b1 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL ack_return got ready=%b done=%b exp 1 0", ready4, done4);
    end
    n_chk++; if (p4 !== e) begin n_fail++; $display("FAIL p_after_ack got %0d exp %0d", p4, e); end
  endtask

  task automatic test_patterns();
    int v[3][3] = '{'{9, 7, 3}, '{0, 13, 11}, '{6, 0, 0}};
    bit to;
    logic [7:0] e;
    for (int i = 0; i < 3; i++) begin
      start_op4(v[i][0], v[i][1], v[i][2]);
      wait_done4(to);
      e = q4.pop_front();
      n_chk++; if (to) begin n_fail++; $display("FAIL pattern%0d_timeout got done=0 exp 1", i); end
      n_chk++; if (p4 !== e) begin n_fail++; $display("FAIL pattern%0d_p got %0d exp %0d", i, p4, e); end
      do_ack4();
    end
  endtask

  task automatic test_start_ignored();
    bit to;
    logic [7:0] e;
    start_op4(5, 5, 0);
    start4 = 1'b1; x4 = 4'd3; y4 = 4'd3; c4 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", ready4); end
      @(negedge clock);
    end
    wait_done4(to);
    e = q4.pop_front();
    n_chk++; if (to) begin n_fail++; $display("FAIL ignore_timeout got done=0 exp 1"); end
    for (int i = 0; i < 2; i++) begin
      n_chk++; if (p4 !== e || done4 !== 1'b1 || ready4 !== 1'b0) begin
        n_fail++; $display("FAIL ignore_p got p=%0d done=%b ready=%b exp %0d 1 0", p4, done4, ready4, e);
      end
      @(negedge clock);
    end
    start4 = 1'b0;
    do_ack4();
    @(negedge clock);
    n_chk++; if (ready4 !== 1'b1 || done4 !== 1'b0 || p4 !== e) begin
      n_fail++; $display("FAIL ignore_no_second got ready=%b done=%b p=%0d exp 1 0 %0d", ready4, done4, p4, e);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    logic [7:0] e;
    start_op4(9, 7, 3);
    void'(q4.pop_back());
    @(negedge clock);
    reset_ = 1'b0;
    #1;
    n_chk++; if (ready4 !== 1'b1 || done4 !== 1'b0 || p4 !== 8'd0) begin
      n_fail++; $display("FAIL midreset got ready=%b done=%b p=%0d exp 1 0 0", ready4, done4, p4);
    end
    @(negedge clock);
    reset_ = 1'b1;
    repeat (6) begin
      @(negedge clock);
      n_chk++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL midreset_no_done got %b exp 0", done4); end
    end
    start_op4(2, 3, 1);
    wait_done4(to);
    e = q4.pop_front();
    n_chk++; if (to) begin n_fail++; $display("FAIL postreset_timeout got done=0 exp 1"); end
    n_chk++; if (p4 !== e) begin n_fail++; $display("FAIL postreset_p got %0d exp %0d", p4, e); end
    do_ack4();
  endtask

  task automatic test_start_ack_same();
    bit to;
    logic [7:0] e;
    start_op4(4, 4, 4);
    wait_done4(to);
    e = q4.pop_front();
    n_chk++; if (to || p4 !== e) begin n_fail++; $display("FAIL sa_first got done=%b p=%0d exp 1 %0d", done4, p4, e); end
    x4 = 4'd1; y4 = 4'd1; c4 = 4'd1;
    start4 = 1'b1; ack4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0; ack4 = 1'b0;
    n_chk++; if (ready4 !== 1'b1 || done4 !== 1'b0) begin
      n_fail++; $display("FAIL sa_idle got ready=%b done=%b exp 1 0", ready4, done4);
    end
    @(negedge clock);
    n_chk++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL sa_no_op got ready=%b exp 1", ready4); end
    start_op4(1, 1, 1);
    wait_done4(to);
    e = q4.pop_front();
    n_chk++; if (to || p4 !== e) begin n_fail++; $display("FAIL sa_next got done=%b p=%0d exp 1 %0d", done4, p4, e); end
    do_ack4();
  endtask

  task automatic test_n8();
    bit to;
    int d;
    logic [15:0] e;
    start_op8(255, 255, 255);
    for (int i = 0; i < 8; i++) begin
      n_chk++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL n8_latency step %0d got 1 exp 0", i); end
      @(negedge clock);
    end
    e = q8.pop_front();
    n_chk++; if (done8 !== 1'b1 || p8 !== e) begin
      n_fail++; $display("FAIL n8_max got done=%b p=%0d exp 1 %0d", done8, p8, e);
    end
    do_ack8();
    for (int k = 0; k < 1000; k++) begin
      start_op8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      wait_done8(to);
      e = q8.pop_front();
      n_chk++; if (to || p8 !== e) begin
        n_fail++; $display("FAIL n8_rand%0d got done=%b p=%0d exp 1 %0d (x=%0d y=%0d c=%0d)", k, done8, p8, e, x8, y8, c8);
      end
      d = int'($urandom_range(0, 3));
      repeat (d) @(negedge clock);
      do_ack8();
    end
  endtask

  initial begin
    test_reset();
    test_latency_hold();
    test_patterns();
    test_start_ignored();
    test_reset_mid();
    test_start_ack_same();
    test_n8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
